fir_seq_ctrl: RTL and testbench

Sequencer that runs one filtering job on the genericfir datapath. On a start command it optionally pulses a tap reload, then streams a fixed number of samples into the filter. After the last input it flushes the filter with zeros, keeping the clock enable running, until the requested number of results has been collected. Results go out on a valid/ready stream with backpressure. The block sits between the sample source / result sink and the FIR, and replaces the hand-driven ce / end-of-input / clean-pipe sequencing.

---
 rtl/fir_seq_ctrl.sv | 102 ++++++++++
 tb/tb_fir_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: runs one FIR job (tap reload, sample stream, zero flush, result stream); FIR_SEQ_PERF_EN adds perf counters
module fir_seq_ctrl #(
  parameter int NTAPS = 8,
  parameter int IW = 12,
  parameter int OW = 31,
  parameter int CNTW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [CNTW-1:0]      i_num_samples,
  input  logic [CNTW-1:0]      i_out_len,
  input  logic                 i_tap_load,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 s_valid,
  input  logic signed [IW-1:0] s_data,
  output logic                 s_ready,
  output logic                 o_fir_ce,
  output logic signed [IW-1:0] o_fir_sample,
  output logic                 o_fir_tap_wr,
  input  logic signed [OW-1:0] i_fir_result,
  input  logic                 i_fir_valid_result,
  input  logic                 i_fir_clean_pip,
  output logic                 m_valid,
  output logic signed [OW-1:0] m_data,
  output logic                 m_last,
  input  logic                 m_ready
`ifdef FIR_SEQ_PERF_EN
  ,
  output logic [31:0]          o_cyc_cnt,
  output logic [31:0]          o_stall_cnt,
  output logic [15:0]          o_flush_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, TAPLOAD, STREAM, FLUSH, DONE} state_t;
  localparam logic [CNTW:0] EXTRA = (CNTW+1)'(NTAPS + 1);
  state_t state, state_nx;
  logic [CNTW-1:0] n_reg, l_reg, smp_cnt, res_cnt, l_nx;
  logic [CNTW:0] def_len;
  logic stall, start_ok, hs, capture, last_cap, last_smp;
  always_comb begin
    stall = m_valid && !m_ready;
    start_ok = state == IDLE && i_start && i_num_samples != '0;
    def_len = {1'b0, i_num_samples} + EXTRA;
    l_nx = i_out_len != '0 ? i_out_len : def_len[CNTW] ? '1 : def_len[CNTW-1:0];
    s_ready = state == STREAM && !stall;
    o_fir_ce = state == STREAM ? s_valid && !stall : state == FLUSH && !stall;
    o_fir_sample = state == STREAM ? s_data : '0;
    o_fir_tap_wr = state == TAPLOAD;
    o_busy = state != IDLE;
    o_done = state == DONE && !m_valid;
    hs = s_valid && s_ready;
    capture = o_fir_ce && i_fir_valid_result && res_cnt < l_reg;
    last_cap = capture && res_cnt + CNTW'(1) == l_reg;
    last_smp = hs && smp_cnt + CNTW'(1) == n_reg;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_ok ? (i_tap_load ? TAPLOAD : STREAM) : IDLE;
      TAPLOAD: state_nx = STREAM;
      STREAM:  state_nx = last_cap ? DONE : last_smp ? FLUSH : STREAM;
      FLUSH:   state_nx = last_cap ? DONE : FLUSH;
      DONE:    state_nx = m_valid ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= IDLE;
      n_reg <= '0;
      l_reg <= '0;
      smp_cnt <= '0;
      res_cnt <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
    end else begin
      state <= state_nx;
      n_reg <= start_ok ? i_num_samples : n_reg;
      l_reg <= start_ok ? l_nx : l_reg;
      smp_cnt <= start_ok ? '0 : hs ? smp_cnt + CNTW'(1) : smp_cnt;
      res_cnt <= start_ok ? '0 : capture ? res_cnt + CNTW'(1) : res_cnt;
      m_valid <= capture || stall;
      m_data <= capture ? i_fir_result : m_data;
      m_last <= capture ? last_cap : m_last && !m_ready;
    end
`ifdef FIR_SEQ_PERF_EN
  always_ff @(posedge i_clk)
    if (i_reset || start_ok) begin
      o_cyc_cnt <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      o_cyc_cnt <= o_busy && o_cyc_cnt != '1 ? o_cyc_cnt + 32'd1 : o_cyc_cnt;
      o_stall_cnt <= o_busy && stall && o_stall_cnt != '1 ? o_stall_cnt + 32'd1 : o_stall_cnt;
      o_flush_cnt <= state == FLUSH && !i_fir_clean_pip && o_flush_cnt != '1 ? o_flush_cnt + 16'd1 : o_flush_cnt;
    end
`else
  logic unused;
  assign unused = i_fir_clean_pip;
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: randomized self-checking bench for fir_seq_ctrl against a convolution model
`timescale 1ns/1ps
module tb_fir_seq_ctrl;
  localparam int NTAPS = 8, IW = 12, OW = 31, CNTW = 16, LAT = 2;
  logic i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_tap_load = 1'b0;
  logic [CNTW-1:0] i_num_samples = '0, i_out_len = '0;
  logic o_busy, o_done, s_valid = 1'b0, s_ready, o_fir_ce, o_fir_tap_wr;
  logic signed [IW-1:0] s_data = '0, o_fir_sample;
  logic signed [OW-1:0] i_fir_result, m_data;
  logic i_fir_valid_result, i_fir_clean_pip, m_valid, m_last, m_ready = 1'b0;
`ifdef FIR_SEQ_PERF_EN
  logic [31:0] o_cyc_cnt, o_stall_cnt;
  logic [15:0] o_flush_cnt;
`endif
  always #5 i_clk = ~i_clk;
  fir_seq_ctrl #(.NTAPS(NTAPS), .IW(IW), .OW(OW), .CNTW(CNTW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_num_samples(i_num_samples),
    .i_out_len(i_out_len), .i_tap_load(i_tap_load), .o_busy(o_busy), .o_done(o_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .o_fir_ce(o_fir_ce),
    .o_fir_sample(o_fir_sample), .o_fir_tap_wr(o_fir_tap_wr), .i_fir_result(i_fir_result),
    .i_fir_valid_result(i_fir_valid_result), .i_fir_clean_pip(i_fir_clean_pip),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
`ifdef FIR_SEQ_PERF_EN
    , .o_cyc_cnt(o_cyc_cnt), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
  );
  int new_h [0:NTAPS];
  int mh [0:NTAPS];
  int act_h [0:NTAPS];
  int x [0:255];
  longint exp_d [0:511];
  logic signed [IW-1:0] dl [0:NTAPS-1];
  logic signed [OW-1:0] pipe [0:LAT-1];
  int vcnt;
  logic fir_rst = 1'b0;
  int exp_len = 0, ridx = 0, tap_cnt = 0, ce_cnt = 0, done_cnt = 0, busy_cyc = 0, stall_cyc = 0;
  bit job_on = 1'b0, job_clr = 1'b0, want_done = 1'b0;
  int cmp_n = 0, fail_n = 0;
  always @(posedge i_clk) begin
    longint acc;
    if (i_reset) for (int k = 0; k <= NTAPS; k++) act_h[k] <= k + 1;
    else if (o_fir_tap_wr) for (int k = 0; k <= NTAPS; k++) act_h[k] <= new_h[k];
    if (i_reset || fir_rst) begin
      for (int k = 0; k < NTAPS; k++) dl[k] <= '0;
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
      vcnt <= 0;
    end else if (o_fir_ce) begin
      acc = longint'(o_fir_sample) * act_h[0];
      for (int k = 1; k <= NTAPS; k++) acc += longint'(dl[k-1]) * act_h[k];
      dl[0] <= o_fir_sample;
      for (int k = 1; k < NTAPS; k++) dl[k] <= dl[k-1];
      pipe[0] <= acc[OW-1:0];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (vcnt < LAT) vcnt <= vcnt + 1;
    end
  end
  assign i_fir_result = pipe[LAT-1];
  assign i_fir_valid_result = vcnt >= LAT;
  always_comb begin
    i_fir_clean_pip = 1'b1;
    for (int k = 0; k < NTAPS; k++) if (dl[k] != '0) i_fir_clean_pip = 1'b0;
  end
  task automatic check(input string nm, input longint got, input longint want);
    cmp_n++;
    if (got != want) begin
      fail_n++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, got, want, $time);
    end
  endtask
  always @(negedge i_clk) begin
    if (job_clr) begin
      ridx = 0; tap_cnt = 0; ce_cnt = 0; done_cnt = 0; busy_cyc = 0; stall_cyc = 0; want_done = 1'b0;
    end else if (job_on) begin
      if (want_done) check("done_after_last", o_done, 1);
      want_done = 1'b0;
      if (o_busy) busy_cyc++;
      if (o_busy && m_valid && !m_ready) stall_cyc++;
      if (m_valid && !m_ready) begin
        check("stall_ce", o_fir_ce, 0);
        check("stall_s_ready", s_ready, 0);
      end
      if (o_fir_tap_wr) begin
        tap_cnt++;
        check("tap_wr_ce", o_fir_ce, 0);
        check("tap_wr_before_ce", ce_cnt, 0);
      end
      if (o_fir_ce) begin
        ce_cnt++;
        check("fir_sample", o_fir_sample, s_ready ? longint'(s_data) : 0);
      end
      if (o_done) done_cnt++;
      if (m_valid && m_ready) begin
        if (ridx < exp_len) begin
          check("m_data", m_data, exp_d[ridx]);
          check("m_last", m_last, ridx == exp_len - 1);
          want_done = ridx == exp_len - 1;
        end else check("extra_result", ridx + 1, exp_len);
        ridx++;
      end
    end
  end
  task automatic run_job(input int n, input int ol, input bit ld, input int gmode, input int rmode, input bit dbl);
    int l, sidx, inj;
    longint s;
    if (ld) for (int k = 0; k <= NTAPS; k++) mh[k] = new_h[k];
    l = ol != 0 ? ol : n + NTAPS + 1;
    exp_len = l;
    for (int j = 0; j < l; j++) begin
      s = 0;
      for (int k = 0; k <= NTAPS; k++) if (j - k >= 0 && j - k < n) s += longint'(mh[k]) * x[j-k];
      exp_d[j] = s;
    end
    @(posedge i_clk); #1;
    fir_rst = 1'b1; job_clr = 1'b1; i_start = 1'b1;
    i_num_samples = CNTW'(n); i_out_len = CNTW'(ol); i_tap_load = ld;
    s_valid = 1'b0; m_ready = 1'b0;
    @(posedge i_clk); #1;
    fir_rst = 1'b0; job_clr = 1'b0; job_on = 1'b1; i_start = 1'b0;
    i_num_samples = CNTW'($urandom); i_out_len = CNTW'($urandom); i_tap_load = 1'($urandom);
    sidx = 0; inj = 0;
    for (int cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
      s_valid = gmode == 0 ? 1'b1 : gmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      s_data = sidx < n ? IW'(x[sidx]) : IW'($urandom);
      m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) :
                rmode == 2 ? 1'($urandom_range(0, 1)) : !(inj < 2 && m_valid);
      if (rmode == 3 && !m_ready) inj++;
      i_start = dbl && cyc == 6;
      if (dbl && cyc == 6) begin
        i_num_samples = CNTW'(3); i_out_len = CNTW'(1);
      end
      @(negedge i_clk);
      if (dbl && cyc == 6) check("busy_at_restart", o_busy, 1);
      if (s_valid && s_ready) sidx++;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0; m_ready = 1'b1; s_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    job_on = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("results", ridx, exp_len);
    check("tap_wr_pulses", tap_cnt, ld);
    check("consumed", sidx, l + LAT <= n ? l + LAT : n);
    check("idle_after", o_busy, 0);
`ifdef FIR_SEQ_PERF_EN
    check("cyc_cnt", o_cyc_cnt, busy_cyc);
    check("stall_cnt", o_stall_cnt, stall_cyc);
`endif
  endtask
  initial begin
    int sidx, dn;
    for (int k = 0; k <= NTAPS; k++) begin
      new_h[k] = k + 1;
      mh[k] = k + 1;
    end
    s_data = 12'sd5; s_valid = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_ce", o_fir_ce, 0);
    check("rst_tap_wr", o_fir_tap_wr, 0);
    check("rst_fir_sample", o_fir_sample, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0; s_valid = 1'b0;
    for (int k = 0; k <= NTAPS; k++) new_h[k] = 8 + k;
    for (int i = 0; i < 256; i++) x[i] = i == 0 ? 1 : 0;
    run_job(8, 0, 1'b1, 0, 0, 1'b0);
    check("pin_len", exp_len, 17);
    check("pin_y0", exp_d[0], 8);
    check("pin_y8", exp_d[8], 16);
    check("pin_y9", exp_d[9], 0);
    run_job(8, 0, 1'b1, 0, 1, 1'b0);
    run_job(8, 0, 1'b1, 1, 0, 1'b0);
    run_job(8, 3, 1'b1, 0, 0, 1'b0);
    check("pin_short_y2", exp_d[2], 10);
    run_job(8, 0, 1'b0, 0, 3, 1'b0);
`ifdef FIR_SEQ_PERF_EN
    check("stall_cnt_two", o_stall_cnt, 2);
`endif
    for (int i = 0; i < 256; i++) x[i] = $urandom_range(0, 4095) - 2048;
    run_job(10, 0, 1'b0, 2, 2, 1'b1);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_num_samples = '0; i_out_len = CNTW'(5); i_tap_load = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    check("n0_idle", o_busy, 0);
    check("n0_no_tap_wr", o_fir_tap_wr, 0);
    for (int j = 0; j < 12; j++) begin
      int n, ol;
      n = $urandom_range(1, 24);
      ol = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, n + NTAPS + 3);
      for (int k = 0; k <= NTAPS; k++) new_h[k] = $urandom_range(0, 255) - 128;
      for (int i = 0; i < 256; i++) x[i] = $urandom_range(0, 4095) - 2048;
      run_job(n, ol, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
    @(posedge i_clk); #1;
    fir_rst = 1'b1; i_start = 1'b1; i_num_samples = CNTW'(4); i_out_len = '0; i_tap_load = 1'b0;
    m_ready = 1'b1; s_valid = 1'b1;
    @(posedge i_clk); #1;
    fir_rst = 1'b0; i_start = 1'b0;
    sidx = 0;
    for (int c = 0; c < 100 && sidx < 4; c++) begin
      s_data = IW'(x[sidx]);
      @(negedge i_clk);
      if (s_valid && s_ready) sidx++;
      @(posedge i_clk); #1;
    end
    check("rst_test_streamed", sidx, 4);
    m_ready = 1'b0; s_valid = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("flush_busy", o_busy, 1);
    check("flush_m_valid", m_valid, 1);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0; m_ready = 1'b1;
    for (int k = 0; k <= NTAPS; k++) mh[k] = k + 1;
    @(negedge i_clk);
    check("midrst_busy", o_busy, 0);
    check("midrst_m_valid", m_valid, 0);
    dn = 0;
    repeat (4) begin
      if (o_done) dn++;
      @(negedge i_clk);
    end
    check("midrst_no_done", dn, 0);
    for (int i = 0; i < 256; i++) x[i] = $urandom_range(0, 4095) - 2048;
    run_job(6, 0, 1'b0, 2, 2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
